// File: rtl/mips_register_file_pkg.sv
// ---------------------------------------------------------------------------
// mips_register_file_pkg
// Shared constants for the MIPS register file, the 32-bit ALU and its
// control unit. Keeping them here means the three blocks cannot disagree on
// datapath width, register count or the hard-wired zero register index.
// ---------------------------------------------------------------------------
package mips_register_file_pkg;

  localparam int DATA_W    = 32;           // register / datapath width
  localparam int ADDR_W    = 5;            // register index width
  localparam int REG_COUNT = 2 ** ADDR_W;  // number of architectural registers
  localparam int ZERO_REG  = 0;            // index that always reads as zero

endpackage : mips_register_file_pkg

// File: rtl/mips_register_file_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file. The address is sampled on
// the rising edge together with the selected storage word. The port
// bypasses a write landing on the same index in the same edge, so the
// caller sees the new value. Index zero is masked to all-zeros.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   rd_addr     - read index, sampled every rising edge
//   mem_data    - current storage contents at rd_addr (combinational)
//   wr_en       - write strobe of the shared write port
//   wr_addr     - write index of the shared write port
//   wr_data     - write data of the shared write port
//   rd_data     - registered read data
// ---------------------------------------------------------------------------
module regfile_read_port
  import mips_register_file_pkg::*;
#(
  parameter int P_DATA_W = mips_register_file_pkg::DATA_W,
  parameter int P_ADDR_W = mips_register_file_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P_ADDR_W-1:0] rd_addr,
  input  logic [P_DATA_W-1:0] mem_data,
  input  logic                wr_en,
  input  logic [P_ADDR_W-1:0] wr_addr,
  input  logic [P_DATA_W-1:0] wr_data,
  output logic [P_DATA_W-1:0] rd_data
);

  logic [P_DATA_W-1:0] rd_data_d;
  logic [P_DATA_W-1:0] rd_data_q;
  logic                addr_is_zero;
  logic                bypass_hit;

  assign addr_is_zero = (rd_addr == P_ADDR_W'(ZERO_REG));
  // A write to index zero can never hit here: rd_addr==0 is masked first.
  assign bypass_hit   = wr_en && (wr_addr == rd_addr);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves rd_data_d
    // unassigned; otherwise synthesis infers a latch.
    rd_data_d = mem_data;
    if (addr_is_zero) begin
      rd_data_d = '0;
    end else if (bypass_hit) begin
      rd_data_d = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : regfile_read_port

// File: rtl/mips_register_file.sv
// ---------------------------------------------------------------------------
// mips_register_file
// MIPS-style register file. It has two registered read ports with
// write-first bypass, one write port and the captured ALU status flags.
// Register 0 is hard-wired to zero. Read data appears one cycle after the
// address is presented.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   rd_addr_a/rd_addr_b   - read indices (sampled each rising edge)
//   rd_data_a/rd_data_b   - registered read data (ALU operands a/b)
//   wr_en/wr_addr/wr_data - ALU result write port
//   flag_en               - capture strobe for the ALU flags
//   carry_in/zero_in      - ALU carry-out and zero flag to capture
//   flag_carry/flag_zero  - registered flags
// ---------------------------------------------------------------------------
module mips_register_file
  import mips_register_file_pkg::*;
#(
  parameter int DATA_W = mips_register_file_pkg::DATA_W,
  parameter int ADDR_W = mips_register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_en,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              flag_carry,
  output logic              flag_zero
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              write_ok;
  logic              flag_carry_d, flag_carry_q;
  logic              flag_zero_d,  flag_zero_q;

  // Writes to the zero register are dropped, so mem_q[0] stays at reset 0.
  assign write_ok = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

  // Per-index write decode.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (write_ok && (wr_addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;
    if (flag_en) begin
      flag_carry_d = carry_in;
      flag_zero_d  = zero_in;
    end
  end

  // NOTE: the storage array is reset explicitly. Every register must read 0
  // while rst_n is low and after release, so it is built from resettable
  // flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
    end
  end

  regfile_read_port #(
    .P_DATA_W (DATA_W),
    .P_ADDR_W (ADDR_W)
  ) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr_a),
    .mem_data (mem_q[rd_addr_a]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_a)
  );

  regfile_read_port #(
    .P_DATA_W (DATA_W),
    .P_ADDR_W (ADDR_W)
  ) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr_b),
    .mem_data (mem_q[rd_addr_b]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_b)
  );

  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// ---------------------------------------------------------------------------
// tb_mips_register_file
// Self-checking bench for mips_register_file. It runs a directed vector
// table, hand-written reset sequences, a full index sweep and a randomized
// run. The randomized run is checked against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        flag_en = 1'b0;
  logic        carry_in = 1'b0;
  logic        zero_in = 1'b0;
  logic        flag_carry;
  logic        flag_zero;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state and the expectation for the most recent edge.
  logic [31:0] model_regs [32];
  logic        model_c, model_z;
  logic [31:0] exp_a, exp_b;
  logic        exp_c, exp_z;

  mips_register_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flag_en    (flag_en),
    .carry_in   (carry_in),
    .zero_in    (zero_in),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        fe;
    logic        ci;
    logic        zi;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ec;
    logic        ez;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_c = 1'b0;
    model_z = 1'b0;
  endtask

  // Advance one clock: compute what the edge should produce from the
  // architectural rules, commit it to the model, then sample #1 after the edge.
  task automatic tick();
    if (!rst_n) begin
      model_clear();
      exp_a = '0;
      exp_b = '0;
    end else begin
      exp_a = (rd_addr_a == 0) ? 32'h0 :
              (wr_en && wr_addr == rd_addr_a) ? wr_data : model_regs[rd_addr_a];
      exp_b = (rd_addr_b == 0) ? 32'h0 :
              (wr_en && wr_addr == rd_addr_b) ? wr_data : model_regs[rd_addr_b];
      if (wr_en && wr_addr != 0) model_regs[wr_addr] = wr_data;
      if (flag_en) begin
        model_c = carry_in;
        model_z = zero_in;
      end
    end
    exp_c = model_c;
    exp_z = model_z;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic fe, input logic ci, input logic zi);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    flag_en = fe; carry_in = ci; zero_in = zi;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a"}, rd_data_a, 32'h0);
    check({name, "_b"}, rd_data_b, 32'h0);
    check({name, "_c"}, {31'h0, flag_carry}, 32'h0);
    check({name, "_z"}, {31'h0, flag_zero}, 32'h0);
  endtask

  initial begin
    model_clear();

    // Directed table, applied in order (each row depends on prior rows).
    vecs[0] = '{we:0, wa:0, wd:32'h0,        ra:0, rb:0, fe:0, ci:0, zi:0,
                ea:32'h0,        eb:32'h0,        ec:0, ez:0};
    vecs[1] = '{we:1, wa:5, wd:32'hEDA5B56A, ra:1, rb:2, fe:0, ci:0, zi:0,
                ea:32'h0,        eb:32'h0,        ec:0, ez:0};
    vecs[2] = '{we:0, wa:0, wd:32'h0,        ra:5, rb:5, fe:0, ci:0, zi:0,
                ea:32'hEDA5B56A, eb:32'hEDA5B56A, ec:0, ez:0};
    vecs[3] = '{we:1, wa:7, wd:32'h2A2A2A2A, ra:7, rb:7, fe:0, ci:0, zi:0,
                ea:32'h2A2A2A2A, eb:32'h2A2A2A2A, ec:0, ez:0};
    vecs[4] = '{we:1, wa:0, wd:32'hFFFFFFFF, ra:0, rb:0, fe:0, ci:0, zi:0,
                ea:32'h0,        eb:32'h0,        ec:0, ez:0};
    vecs[5] = '{we:0, wa:0, wd:32'h0,        ra:7, rb:0, fe:0, ci:0, zi:0,
                ea:32'h2A2A2A2A, eb:32'h0,        ec:0, ez:0};
    vecs[6] = '{we:0, wa:0, wd:32'h0,        ra:5, rb:7, fe:1, ci:1, zi:0,
                ea:32'hEDA5B56A, eb:32'h2A2A2A2A, ec:1, ez:0};
    vecs[7] = '{we:0, wa:0, wd:32'h0,        ra:0, rb:5, fe:0, ci:0, zi:1,
                ea:32'h0,        eb:32'hEDA5B56A, ec:1, ez:0};
    vecs[8] = '{we:1, wa:3, wd:32'h13572468, ra:3, rb:5, fe:1, ci:0, zi:1,
                ea:32'h13572468, eb:32'hEDA5B56A, ec:0, ez:1};

    // Initial reset: outputs must be zero while rst_n is low.
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset_init");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb,
            vecs[i].fe, vecs[i].ci, vecs[i].zi);
      tick();
      check($sformatf("vec%0d_a", i), rd_data_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), rd_data_b, vecs[i].eb);
      check($sformatf("vec%0d_c", i), {31'h0, flag_carry}, {31'h0, vecs[i].ec});
      check($sformatf("vec%0d_z", i), {31'h0, flag_zero}, {31'h0, vecs[i].ez});
    end

    // Mid-run asynchronous reset: outputs clear before any clock edge.
    drive(0, 0, 0, 5, 7, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    // A write and flag capture during reset are lost.
    drive(1, 9, 32'hDEADBEEF, 9, 9, 1, 1, 1);
    tick();
    check_all_zero("reset_hold");
    #2 rst_n = 1'b1;
    // Prior writes are gone; read r5/r7 on the first edge after release.
    drive(0, 0, 0, 5, 7, 0, 0, 0);
    tick();
    check_all_zero("reset_cleared");
    drive(0, 0, 0, 9, 3, 0, 0, 0);
    tick();
    check("reset_lost_wr_a", rd_data_a, 32'h0);
    check("reset_lost_wr_b", rd_data_b, 32'h0);
    // Reset release followed immediately by a working bypassed write.
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    drive(1, 4, 32'hA5A5F00D, 4, 0, 1, 1, 1);
    tick();
    check("post_reset_byp_a", rd_data_a, 32'hA5A5F00D);
    check("post_reset_byp_b", rd_data_b, 32'h0);
    check("post_reset_c", {31'h0, flag_carry}, 32'h1);
    check("post_reset_z", {31'h0, flag_zero}, 32'h1);

    // Sweep: write index i into r1..r31, then read every pair.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i), 0, 0, 0, 0, 0);
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        drive(0, 0, 0, 5'(a), 5'(b), 0, 0, 0);
        tick();
        check($sformatf("sweep_a%0d", a), rd_data_a, 32'(a));
        check($sformatf("sweep_b%0d", b), rd_data_b, 32'(b));
      end
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom), wa, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      check("rand_a", rd_data_a, exp_a);
      check("rand_b", rd_data_b, exp_b);
      check("rand_c", {31'h0, flag_carry}, {31'h0, exp_c});
      check("rand_z", {31'h0, flag_zero}, {31'h0, exp_z});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mips_register_file
